// File: rtl/gray_step_sequencer.sv
// Command-driven Gray-code position sequencer: walks a binary index up or down by a
// programmed step count, publishing its Gray code and pulsing done/wrap.
module gray_step_sequencer #(
   parameter int unsigned WIDTH = 3,
   parameter int unsigned CNT_W = 8
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             cmd_valid,
   output logic             cmd_ready,
   input  logic             cmd_dir,
   input  logic [CNT_W-1:0] cmd_steps,
   input  logic             hold,
   input  logic             abort,
   output logic [WIDTH-1:0] y,
   output logic             busy,
   output logic             done,
   output logic             wrap
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_RUN  = 2'd1,
      ST_DONE = 2'd2
   } state_e;

   localparam logic [WIDTH-1:0] IDX_MAX = '1;

   state_e             state_q, state_d;
   logic [WIDTH-1:0]   idx_q, idx_d;
   logic [CNT_W-1:0]   rem_q, rem_d;
   logic               dir_q, dir_d;
   logic [WIDTH-1:0]   y_q, y_d;
   logic               busy_q, busy_d;
   logic               done_q, done_d;
   logic               wrap_q, wrap_d;
   logic               ready_q, ready_d;

   // Next-state, position stepping and registered-output preparation
   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      rem_d   = rem_q;
      dir_d   = dir_q;
      wrap_d  = 1'b0;

      unique case (state_q)
         ST_IDLE: begin
            if (cmd_valid) begin
               dir_d   = cmd_dir;
               rem_d   = cmd_steps;
               state_d = (cmd_steps != '0) ? ST_RUN : ST_DONE;
            end
         end
         ST_RUN: begin
            if (abort) begin
               state_d = ST_IDLE;
            end else if (!hold) begin
               if (dir_q) begin
                  idx_d  = idx_q - WIDTH'(1);
                  wrap_d = (idx_q == '0);
               end else begin
                  idx_d  = idx_q + WIDTH'(1);
                  wrap_d = (idx_q == IDX_MAX);
               end
               rem_d = rem_q - CNT_W'(1);
               if (rem_q == CNT_W'(1)) begin
                  state_d = ST_DONE;
               end
            end
         end
         ST_DONE: begin
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      // Outputs track the state being entered so they line up with the register edge
      y_d     = idx_d ^ (idx_d >> 1);
      busy_d  = (state_d == ST_RUN);
      done_d  = (state_d == ST_DONE);
      ready_d = (state_d == ST_IDLE);
   end

   // State and output registers with synchronous reset
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         rem_q   <= '0;
         dir_q   <= 1'b0;
         y_q     <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
         wrap_q  <= 1'b0;
         ready_q <= 1'b1;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         rem_q   <= rem_d;
         dir_q   <= dir_d;
         y_q     <= y_d;
         busy_q  <= busy_d;
         done_q  <= done_d;
         wrap_q  <= wrap_d;
         ready_q <= ready_d;
      end
   end

   assign cmd_ready = ready_q;
   assign y         = y_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign wrap      = wrap_q;

endmodule

// File: tb/tb_gray_step_sequencer.sv
// Directed table-driven bench for gray_step_sequencer (WIDTH=3, CNT_W=8).
module tb_gray_step_sequencer;

   logic       clk = 1'b0;
   logic       reset;
   logic       cmd_valid;
   logic       cmd_ready;
   logic       cmd_dir;
   logic [7:0] cmd_steps;
   logic       hold;
   logic       abort;
   logic [2:0] y;
   logic       busy;
   logic       done;
   logic       wrap;

   int checks = 0;
   int errors = 0;

   gray_step_sequencer #(.WIDTH(3), .CNT_W(8)) dut (
      .clk       (clk),
      .reset     (reset),
      .cmd_valid (cmd_valid),
      .cmd_ready (cmd_ready),
      .cmd_dir   (cmd_dir),
      .cmd_steps (cmd_steps),
      .hold      (hold),
      .abort     (abort),
      .y         (y),
      .busy      (busy),
      .done      (done),
      .wrap      (wrap)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic       rst;
      logic       v;
      logic       dir;
      logic [7:0] steps;
      logic       hold;
      logic       abort;
      logic [2:0] y;
      logic       busy;
      logic       done;
      logic       wrap;
      logic       ready;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic rst, input logic v, input logic dir,
                               input logic [7:0] steps, input logic h, input logic a,
                               input logic [2:0] ey, input logic eb, input logic ed,
                               input logic ew, input logic er);
      vec_t r;
      r.rst = rst; r.v = v; r.dir = dir; r.steps = steps; r.hold = h; r.abort = a;
      r.y = ey; r.busy = eb; r.done = ed; r.wrap = ew; r.ready = er;
      return r;
   endfunction

   task automatic chk(input string name, input int row, input logic [7:0] act,
                      input logic [7:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s row %0d: got %0h expected %0h", name, row, act, exp);
      end
   endtask

   task automatic drive(input logic rst, input logic v, input logic dir,
                        input logic [7:0] steps, input logic h, input logic a);
      reset = rst; cmd_valid = v; cmd_dir = dir; cmd_steps = steps; hold = h; abort = a;
      @(posedge clk);
      #1;
   endtask

   task automatic expect_out(input int row, input logic [2:0] ey, input logic eb,
                             input logic ed, input logic ew, input logic er);
      chk("y", row, 8'(y), 8'(ey));
      chk("busy", row, 8'(busy), 8'(eb));
      chk("done", row, 8'(done), 8'(ed));
      chk("wrap", row, 8'(wrap), 8'(ew));
      chk("cmd_ready", row, 8'(cmd_ready), 8'(er));
   endtask

   initial begin
      reset = 1'b1; cmd_valid = 1'b0; cmd_dir = 1'b0; cmd_steps = '0;
      hold = 1'b0; abort = 1'b0;

      // rst v dir steps hold abort | y busy done wrap ready
      vecs.push_back(mk(1,0,0,0,0,0, 3'b000,0,0,0,1));
      // up 8 steps: full Gray cycle with wrap on the final 000
      vecs.push_back(mk(0,1,0,8,0,0, 3'b000,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b001,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b011,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b010,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b110,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b111,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b101,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b100,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b000,0,1,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b000,0,0,0,1));
      // down 3 from 000: wraps to 100
      vecs.push_back(mk(0,1,1,3,0,0, 3'b000,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b100,1,0,1,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b101,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b111,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b111,0,0,0,1));
      // up 5 with two hold cycles after the second step
      vecs.push_back(mk(1,0,0,0,0,0, 3'b000,0,0,0,1));
      vecs.push_back(mk(0,1,0,5,0,0, 3'b000,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b001,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b011,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0, 3'b011,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,1,0, 3'b011,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b010,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b110,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b111,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b111,0,0,0,1));
      // up 6, abort (with hold) after 2 steps, then up 1
      vecs.push_back(mk(1,0,0,0,0,0, 3'b000,0,0,0,1));
      vecs.push_back(mk(0,1,0,6,0,0, 3'b000,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b001,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b011,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,1,1, 3'b011,0,0,0,1));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b011,0,0,0,1));
      vecs.push_back(mk(0,1,0,1,0,0, 3'b011,1,0,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b010,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b010,0,0,0,1));
      // zero-step command: done only, no movement, busy stays low
      vecs.push_back(mk(0,1,0,0,0,0, 3'b010,0,1,0,0));
      vecs.push_back(mk(0,0,0,0,0,0, 3'b010,0,0,0,1));
      // hold and abort outside RUN have no effect
      vecs.push_back(mk(0,0,0,0,1,1, 3'b010,0,0,0,1));

      foreach (vecs[i]) begin
         drive(vecs[i].rst, vecs[i].v, vecs[i].dir, vecs[i].steps, vecs[i].hold,
               vecs[i].abort);
         expect_out(i, vecs[i].y, vecs[i].busy, vecs[i].done, vecs[i].wrap, vecs[i].ready);
      end

      // cmd_valid held high with changed fields during RUN, then reset mid-run at 110
      drive(1,0,0,0,0,0);
      expect_out(100, 3'b000, 0, 0, 0, 1);
      drive(0,1,0,8,0,0);
      expect_out(101, 3'b000, 1, 0, 0, 0);
      drive(0,1,1,3,0,0);
      expect_out(102, 3'b001, 1, 0, 0, 0);
      drive(0,1,1,3,0,0);
      expect_out(103, 3'b011, 1, 0, 0, 0);
      drive(0,1,1,3,0,0);
      expect_out(104, 3'b010, 1, 0, 0, 0);
      drive(0,1,1,3,0,0);
      expect_out(105, 3'b110, 1, 0, 0, 0);
      drive(1,0,0,0,0,0);
      expect_out(106, 3'b000, 0, 0, 0, 1);

      // back-to-back 1-step commands with cmd_valid held high
      drive(0,1,0,1,0,0);
      expect_out(110, 3'b000, 1, 0, 0, 0);
      drive(0,1,0,1,0,0);
      expect_out(111, 3'b001, 0, 1, 0, 0);
      drive(0,1,0,1,0,0);
      expect_out(112, 3'b001, 0, 0, 0, 1);
      drive(0,1,0,1,0,0);
      expect_out(113, 3'b001, 1, 0, 0, 0);
      drive(0,0,0,0,0,0);
      expect_out(114, 3'b011, 0, 1, 0, 0);
      drive(0,0,0,0,0,0);
      expect_out(115, 3'b011, 0, 0, 0, 1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
